// File: rtl/enigma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enigma_pkg
// Description : Shared letter, plugboard op-code and status definitions.
// Revision    : 1.0
// ============================================================================
package enigma_pkg;

    localparam int LETTERS = 26;
    localparam int WIDTH   = 5;

    localparam logic [WIDTH-1:0] LETTER_LIMIT = WIDTH'(LETTERS);
    localparam logic [WIDTH-1:0] LAST_LETTER  = WIDTH'(LETTERS - 1);

    typedef enum logic [WIDTH-1:0] {
        A, B, C, D, E, F, G, H, I, J, K, L, M,
        N, O, P, Q, R, S, T, U, V, W, X, Y, Z
    } letter_e;

    typedef enum logic [1:0] {
        PB_NOP    = 2'd0,
        PB_PLUG   = 2'd1,
        PB_UNPLUG = 2'd2,
        PB_CLEAR  = 2'd3
    } pb_op_e;

    typedef enum logic [2:0] {
        PB_OK          = 3'd0,
        PB_BAD_LETTER  = 3'd1,
        PB_CONFLICT    = 3'd2,
        PB_FULL        = 3'd3,
        PB_NOT_PLUGGED = 3'd4
    } pb_err_e;

    function automatic logic is_letter(input logic [WIDTH-1:0] x);
        return x < LETTER_LIMIT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/plugboard_table.sv
`default_nettype none
// ============================================================================
// Module      : plugboard_table
// Description : 26-entry swap table, identity on reset, dual-entry write and
//               two combinational lookups with out-of-range passthrough.
// Revision    : 1.0
// ============================================================================
module plugboard_table
    import enigma_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we_i,
    input  logic [WIDTH-1:0]              wa0_i,
    input  logic [WIDTH-1:0]              wd0_i,
    input  logic [WIDTH-1:0]              wa1_i,
    input  logic [WIDTH-1:0]              wd1_i,
    input  logic [WIDTH-1:0]              rd0_addr_i,
    output logic [WIDTH-1:0]              rd0_data_o,
    input  logic [WIDTH-1:0]              rd1_addr_i,
    output logic [WIDTH-1:0]              rd1_data_o,
    output logic [LETTERS-1:0][WIDTH-1:0] table_o
);

    logic [LETTERS-1:0][WIDTH-1:0] mem_q;

    // Both halves of a swap land on the same edge so the table never holds a
    // half-written pair.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LETTERS; k++) begin
            if (rst) begin
                mem_q[k] <= WIDTH'(k);
            end else if (we_i && (wa0_i == WIDTH'(k))) begin
                mem_q[k] <= wd0_i;
            end else if (we_i && (wa1_i == WIDTH'(k))) begin
                mem_q[k] <= wd1_i;
            end
        end
    end

    assign rd0_data_o = is_letter(rd0_addr_i) ? mem_q[rd0_addr_i] : rd0_addr_i;
    assign rd1_data_o = is_letter(rd1_addr_i) ? mem_q[rd1_addr_i] : rd1_addr_i;
    assign table_o    = mem_q;

endmodule
`default_nettype wire

// File: rtl/plugboard_config.sv
`default_nettype none
// ============================================================================
// Module      : plugboard_config
// Description : Command-driven plugboard controller: plug, unplug and clear
//               cable pairs, with forward and return lookup paths.
// Revision    : 1.0
// ============================================================================
module plugboard_config
    import enigma_pkg::*;
#(
    parameter int MAX_PAIRS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             rsp_valid,
    output logic [2:0]       rsp_err,
    output logic [3:0]       pair_count,
    output logic             busy,
    input  logic [WIDTH-1:0] fwd_in,
    output logic [WIDTH-1:0] fwd_out,
    input  logic [WIDTH-1:0] ret_in,
    output logic [WIDTH-1:0] ret_out
);

    localparam logic [3:0] MAX_PAIRS_C = 4'(MAX_PAIRS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_EXEC  = 3'd2,
        S_CLR   = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    state_e           state_q;
    pb_op_e           op_q;
    logic [WIDTH-1:0] a_q, b_q, idx_q;
    logic [3:0]       pair_count_q;
    logic             cmd_ready_q, busy_q, rsp_valid_q;
    pb_err_e          rsp_err_q;

    logic [LETTERS-1:0][WIDTH-1:0] w_tbl;
    logic [WIDTH-1:0] w_ta, w_tb, w_ti;
    logic             w_we;
    logic [WIDTH-1:0] w_wa0, w_wd0, w_wa1, w_wd1;
    logic             w_chk_exec, w_chk_clr, w_clr_hit;
    pb_err_e          w_chk_err;

    plugboard_table u_table (
        .clk        (clk),
        .rst        (rst),
        .we_i       (w_we),
        .wa0_i      (w_wa0),
        .wd0_i      (w_wd0),
        .wa1_i      (w_wa1),
        .wd1_i      (w_wd1),
        .rd0_addr_i (fwd_in),
        .rd0_data_o (fwd_out),
        .rd1_addr_i (ret_in),
        .rd1_data_o (ret_out),
        .table_o    (w_tbl)
    );

    assign w_ta      = is_letter(a_q)   ? w_tbl[a_q]   : a_q;
    assign w_tb      = is_letter(b_q)   ? w_tbl[b_q]   : b_q;
    assign w_ti      = is_letter(idx_q) ? w_tbl[idx_q] : idx_q;
    assign w_clr_hit = (w_ti != idx_q);

    // A plug that already exists is reported OK before any conflict check.
    always_comb begin
        w_chk_exec = 1'b0;
        w_chk_clr  = 1'b0;
        w_chk_err  = PB_OK;
        unique case (op_q)
            PB_PLUG: begin
                if (!is_letter(a_q) || !is_letter(b_q) || (a_q == b_q)) begin
                    w_chk_err = PB_BAD_LETTER;
                end else if (w_ta == b_q) begin
                    w_chk_err = PB_OK;
                end else if ((w_ta != a_q) || (w_tb != b_q)) begin
                    w_chk_err = PB_CONFLICT;
                end else if (pair_count_q == MAX_PAIRS_C) begin
                    w_chk_err = PB_FULL;
                end else begin
                    w_chk_exec = 1'b1;
                end
            end
            PB_UNPLUG: begin
                if (!is_letter(a_q)) begin
                    w_chk_err = PB_BAD_LETTER;
                end else if (w_ta == a_q) begin
                    w_chk_err = PB_NOT_PLUGGED;
                end else begin
                    w_chk_exec = 1'b1;
                end
            end
            PB_CLEAR: w_chk_clr = 1'b1;
            default:  w_chk_err = PB_OK;
        endcase
    end

    always_comb begin
        w_we  = 1'b0;
        w_wa0 = a_q;
        w_wd0 = b_q;
        w_wa1 = b_q;
        w_wd1 = a_q;
        if (state_q == S_EXEC) begin
            w_we = 1'b1;
            if (op_q == PB_UNPLUG) begin
                w_wd0 = a_q;
                w_wa1 = w_ta;
                w_wd1 = w_ta;
            end
        end else if (state_q == S_CLR) begin
            w_we  = w_clr_hit;
            w_wa0 = idx_q;
            w_wd0 = idx_q;
            w_wa1 = w_ti;
            w_wd1 = w_ti;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= PB_NOP;
            a_q          <= '0;
            b_q          <= '0;
            idx_q        <= '0;
            pair_count_q <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= PB_OK;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= pb_op_e'(cmd_op);
                        a_q         <= cmd_a;
                        b_q         <= cmd_b;
                        state_q     <= S_CHECK;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_CHECK: begin
                    idx_q <= '0;
                    if (w_chk_clr) begin
                        state_q <= S_CLR;
                    end else if (w_chk_exec) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= w_chk_err;
                    end
                end
                S_EXEC: begin
                    pair_count_q <= (op_q == PB_PLUG) ? pair_count_q + 4'd1
                                                      : pair_count_q - 4'd1;
                    state_q      <= S_RESP;
                    rsp_valid_q  <= 1'b1;
                    rsp_err_q    <= PB_OK;
                end
                S_CLR: begin
                    // A partner already restored reads back as identity, so
                    // each cable is counted down exactly once.
                    if (w_clr_hit) begin
                        pair_count_q <= pair_count_q - 4'd1;
                    end
                    if (idx_q == LAST_LETTER) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= PB_OK;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign pair_count = pair_count_q;

endmodule
`default_nettype wire

// File: tb/tb_plugboard_config.sv
`default_nettype none
// ============================================================================
// Module      : tb_plugboard_config
// Description : Self-checking bench for plugboard_config against a swap-table
//               reference model with directed and random commands.
// Revision    : 1.0
// ============================================================================
module tb_plugboard_config;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [4:0] cmd_a = 5'd0, cmd_b = 5'd0, fwd_in = 5'd0, ret_in = 5'd0;
    logic       cmd_ready, rsp_valid, busy;
    logic [2:0] rsp_err;
    logic [3:0] pair_count;
    logic [4:0] fwd_out, ret_out;

    int n_total = 0;
    int n_pass  = 0;
    int m[26];

    always #5 clk = ~clk;

    plugboard_config #(.MAX_PAIRS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .pair_count (pair_count),
        .busy       (busy),
        .fwd_in     (fwd_in),
        .fwd_out    (fwd_out),
        .ret_in     (ret_in),
        .ret_out    (ret_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int model_pairs();
        int c = 0;
        for (int i = 0; i < 26; i++) if (m[i] > i) c++;
        return c;
    endfunction

    function automatic int model_look(input int x);
        return (x < 26) ? m[x] : x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 26; i++) m[i] = i;
    endtask

    // Sweep every 5-bit code on both lookup ports (only while idle).
    task automatic check_table(input string tag);
        for (int i = 0; i < 32; i++) begin
            fwd_in = 5'(i);
            ret_in = 5'((i + 7) % 32);
            #1;
            check({tag, " fwd"}, fwd_out, model_look(i));
            check({tag, " ret"}, ret_out, model_look((i + 7) % 32));
        end
    endtask

    task automatic do_cmd(input int op, input int a, input int b, input string tag);
        int exp_err, exp_lat, lat, p, x;
        exp_err = 0;
        exp_lat = 2;
        case (op)
            1: begin
                if (a > 25 || b > 25 || a == b)          exp_err = 1;
                else if (m[a] == b)                      exp_err = 0;
                else if (m[a] != a || m[b] != b)         exp_err = 2;
                else if (model_pairs() == 10)            exp_err = 3;
                else begin exp_lat = 3; m[a] = b; m[b] = a; end
            end
            2: begin
                if (a > 25)             exp_err = 1;
                else if (m[a] == a)     exp_err = 4;
                else begin exp_lat = 3; p = m[a]; m[a] = a; m[p] = p; end
            end
            3: begin exp_lat = 28; model_reset(); end
            default: ;
        endcase
        @(negedge clk);
        check({tag, " ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op[1:0];
        cmd_a     = a[4:0];
        cmd_b     = b[4:0];
        @(posedge clk);
        @(negedge clk);
        // Junk on the command port while busy must be ignored.
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 2'($urandom);
        cmd_a     = 5'($urandom);
        cmd_b     = 5'($urandom);
        check({tag, " rsp early"}, rsp_valid, 0);
        check({tag, " busy"}, busy, 1);
        lat = 1;
        while (1) begin
            @(negedge clk);
            lat++;
            x = $urandom_range(0, 25);
            fwd_in = 5'(x);
            #1 ret_in = fwd_out;
            #1;
            check({tag, " involution"}, ret_out, x);
            if (rsp_valid === 1'b1) break;
            if (lat > 40) break;
        end
        cmd_valid = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " err"}, rsp_err, exp_err);
        check({tag, " ready@rsp"}, cmd_ready, 0);
        @(negedge clk);
        check({tag, " rsp pulse"}, rsp_valid, 0);
        check({tag, " ready after"}, cmd_ready, 1);
        check({tag, " busy after"}, busy, 0);
        check({tag, " pairs"}, pair_count, model_pairs());
    endtask

    initial begin
        int op, a, b, r;
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset ready", cmd_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_err", rsp_err, 0);
        check("reset busy", busy, 0);
        check("reset pairs", pair_count, 0);
        check_table("reset");

        do_cmd(1, 0, 4, "plug A-E");
        check_table("after A-E");
        do_cmd(1, 4, 0, "plug E-A again");
        do_cmd(1, 0, 23, "plug A-X");
        do_cmd(1, 2, 2, "plug C-C");
        do_cmd(1, 2, 27, "plug C-27");
        do_cmd(2, 16, 0, "unplug Q");
        do_cmd(0, 0, 0, "nop");
        check_table("after errors");

        for (int k = 0; k < 9; k++) begin
            a = (k == 0) ? 1 : 2 * k + 4;
            b = (k == 0) ? 2 : 2 * k + 5;
            if (k == 1) begin a = 3; b = 5; end
            do_cmd(1, a, b, "fill");
        end
        check("ten pairs", pair_count, 10);
        do_cmd(1, 24, 25, "plug Y-Z full");
        do_cmd(2, 4, 0, "unplug E");
        check_table("after unplug E");
        do_cmd(3, 0, 0, "clear");
        check_table("after clear");

        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 9);
            op = (r < 6) ? 1 : (r < 9) ? 2 : ($urandom_range(0, 1) == 0 ? 0 : 3);
            a  = ($urandom_range(0, 7) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
            b  = ($urandom_range(0, 7) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
            do_cmd(op, a, b, "random");
            check_table("random");
        end

        do_cmd(3, 0, 0, "pre clear");
        do_cmd(1, 0, 25, "plug A-Z");
        do_cmd(1, 3, 20, "plug D-U");
        do_cmd(1, 13, 14, "plug N-O");
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (13) @(negedge clk);
        check("mid clear busy", busy, 1);
        check("mid clear pairs", pair_count, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("abort rsp_valid", rsp_valid, 0);
        check("abort ready", cmd_ready, 1);
        check("abort busy", busy, 0);
        check("abort pairs", pair_count, 0);
        check_table("abort");
        @(negedge clk);
        check("abort no late rsp", rsp_valid, 0);
        do_cmd(1, 6, 7, "plug after abort");
        check_table("after abort plug");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
